// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the VGA text-label overlay: label descriptor,
// default glyph codes and the half-select encoding used in font ROM addresses.
package text_overlay_pkg;

  localparam int QH_W_DEF  = 7;
  localparam int QV_W_DEF  = 10;
  localparam int LEN_W_DEF = 5;

  // Field widths track the default counter widths of text_label_addr_gen.
  typedef struct packed {
    logic [QV_W_DEF-5:0]  row;
    logic [QH_W_DEF-1:0]  col;
    logic [LEN_W_DEF-1:0] len;
    logic                 blink;
  } label_desc_t;

  typedef enum logic {
    HALF_TOP = 1'b0,
    HALF_BOT = 1'b1
  } half_t;

  localparam logic [7:0] GLYPH_SPACE    = 8'h20;
  localparam logic [7:0] GLYPH_DIGIT0   = 8'h30;
  localparam logic [7:0] GLYPH_LETTER_A = 8'h41;

  function automatic logic [7:0] glyph_digit(input logic [3:0] d);
    return GLYPH_DIGIT0 + {4'd0, d};
  endfunction

  function automatic logic [7:0] glyph_letter(input logic [4:0] n);
    return GLYPH_LETTER_A + {3'd0, n};
  endfunction

endpackage

// File: rtl/label_match.sv
// Combinational hit test for one label slot: decides whether the S1 coordinate
// falls inside the double-height label and which character/half it selects.
module label_match
  import text_overlay_pkg::*;
#(
  parameter int QH_W  = QH_W_DEF,
  parameter int QV_W  = QV_W_DEF,
  parameter int IDX_W = 4
)(
  input  label_desc_t       desc,
  input  logic [QH_W-1:0]   qh,
  input  logic [QV_W-5:0]   cell_row,
  input  logic              blink_phase,
  output logic              hit,
  output half_t             half,
  output logic [IDX_W-1:0]  k
);

  logic [QV_W-4:0] row_below;
  logic [QH_W:0]   span;
  logic [QH_W:0]   col_end;
  logic [QH_W-1:0] offset;
  logic            row_top;
  logic            row_bot;
  logic            in_cols;
  logic            blanked;

  always_comb begin
    // One extra bit keeps row+1 from wrapping onto row 0.
    row_below = {1'b0, desc.row} + (QV_W-3)'(1);
    row_top   = (cell_row == desc.row);
    row_bot   = ({1'b0, cell_row} == row_below);
    span      = (QH_W+1)'({desc.len, 1'b0});
    col_end   = {1'b0, desc.col} + span;
    in_cols   = (qh >= desc.col) && ({1'b0, qh} < col_end);
    offset    = qh - desc.col;
    k         = offset[IDX_W:1];
`ifdef LABEL_BLINK_EN
    blanked   = desc.blink & blink_phase;
`else
    blanked   = 1'b0;
`endif
    hit       = (row_top | row_bot) & in_cols & (desc.len != '0) & ~blanked;
    half      = row_top ? HALF_TOP : HALF_BOT;
  end

  logic unused_bits;
`ifdef LABEL_BLINK_EN
  assign unused_bits = ^{offset[0], offset[QH_W-1:IDX_W+1]};
`else
  assign unused_bits = ^{offset[0], offset[QH_W-1:IDX_W+1], blink_phase, desc.blink};
`endif

endmodule

// File: rtl/text_label_addr_gen.sv
// Two-stage glyph-ROM address generator for programmable double-height labels.
// Define LABEL_BLINK_EN to add per-label blinking driven by a frame counter.
module text_label_addr_gen
  import text_overlay_pkg::*;
#(
  parameter  int NUM_LABELS     = 4,
  parameter  int MAX_LEN        = 16,
  parameter  int CODE_W         = 8,
  parameter  int QH_W           = QH_W_DEF,
  parameter  int QV_W           = QV_W_DEF,
  parameter  int ADDR_W         = 20,
  parameter  int BLINK_DIV_LOG2 = 5,
  localparam int SEL_W          = $clog2(NUM_LABELS),
  localparam int IDX_W          = $clog2(MAX_LEN),
  localparam int LEN_W          = IDX_W + 1
)(
  input  logic              reloj,
  input  logic              resetM,
  input  logic [QH_W-1:0]   Qh,
  input  logic [QV_W-1:0]   Qv,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [QV_W-5:0]   cfg_row,
  input  logic [QH_W-1:0]   cfg_col,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_blink,
  input  logic              chr_we,
  input  logic [SEL_W-1:0]  chr_sel,
  input  logic [IDX_W-1:0]  chr_idx,
  input  logic [CODE_W-1:0] chr_code,
  output logic [ADDR_W-1:0] DIR8x16,
  output logic              dir_valid
);

  logic [CODE_W-1:0] text_mem [NUM_LABELS*MAX_LEN];

  logic             s1_vld;
  logic [QH_W-1:0]  s1_qh;
  logic [QV_W-5:0]  s1_cell_row;
  logic [3:0]       s1_line;
  logic             blink_phase;

  logic [NUM_LABELS-1:0] hit;
  half_t                 half_sel [NUM_LABELS];
  logic [IDX_W-1:0]      k        [NUM_LABELS];

  logic              win_any;
  logic [SEL_W-1:0]  win_sel;
  logic [IDX_W-1:0]  win_k;
  half_t             win_half;

  logic [CODE_W-1:0] code_q;
  logic              out_vld;
  half_t             out_half;
  logic [3:0]        out_line;

  always_ff @(posedge reloj) begin
    if (resetM) begin
      s1_vld      <= 1'b0;
      s1_qh       <= '0;
      s1_cell_row <= '0;
      s1_line     <= '0;
    end else begin
      s1_vld      <= 1'b1;
      s1_qh       <= Qh;
      s1_cell_row <= Qv[QV_W-1:4];
      s1_line     <= Qv[3:0];
    end
  end

  for (genvar gi = 0; gi < NUM_LABELS; gi++) begin : g_slot
    label_desc_t desc_reg;

    always_ff @(posedge reloj) begin
      if (resetM) begin
        desc_reg <= '0;
      end else if (cfg_we && cfg_sel == SEL_W'(gi)) begin
        desc_reg.row <= cfg_row;
        desc_reg.col <= cfg_col;
        desc_reg.len <= cfg_len;
`ifdef LABEL_BLINK_EN
        desc_reg.blink <= cfg_blink;
`else
        desc_reg.blink <= 1'b0;
`endif
      end
    end

    label_match #(.QH_W(QH_W), .QV_W(QV_W), .IDX_W(IDX_W)) u_match (
      .desc        (desc_reg),
      .qh          (s1_qh),
      .cell_row    (s1_cell_row),
      .blink_phase (blink_phase),
      .hit         (hit[gi]),
      .half        (half_sel[gi]),
      .k           (k[gi])
    );
  end

  // Scan from the top slot down so the lowest-index hit is the one left standing.
  always_comb begin
    win_any  = 1'b0;
    win_sel  = '0;
    win_k    = '0;
    win_half = HALF_TOP;
    for (int i = NUM_LABELS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_any  = 1'b1;
        win_sel  = SEL_W'(i);
        win_k    = k[i];
        win_half = half_sel[i];
      end
    end
  end

  // Read-before-write: a lookup colliding with a text write sees the old code.
  always_ff @(posedge reloj) begin
    if (chr_we) begin
      text_mem[{chr_sel, chr_idx}] <= chr_code;
    end
    code_q <= text_mem[{win_sel, win_k}];
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      out_vld  <= 1'b0;
      out_half <= HALF_TOP;
      out_line <= '0;
    end else begin
      out_vld  <= s1_vld & win_any;
      out_half <= win_half;
      out_line <= s1_line;
    end
  end

  assign dir_valid = out_vld;
  assign DIR8x16   = out_vld ? ADDR_W'({code_q, out_half, out_line}) : '0;

`ifdef LABEL_BLINK_EN
  logic [BLINK_DIV_LOG2-1:0] frame_cnt;

  // Count at the edge where registered Qv drops to 0, so line 0 already sees the new frame.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      frame_cnt <= '0;
    end else if (s1_vld && {s1_cell_row, s1_line} != '0 && Qv == '0) begin
      frame_cnt <= frame_cnt + BLINK_DIV_LOG2'(1);
    end
  end

  assign blink_phase = frame_cnt[BLINK_DIV_LOG2-1];
`else
  logic unused_cfg;
  assign blink_phase = 1'b0;
  assign unused_cfg  = cfg_blink ^ (BLINK_DIV_LOG2 > 0);
`endif

endmodule

// File: tb/tb_text_label_addr_gen.sv
// Scoreboard bench for text_label_addr_gen: directed test-plan lookups plus
// randomized programming/scanning checked against a label-level reference model.
`timescale 1ns/1ps
module tb_text_label_addr_gen;

  localparam int NL = 4;
  localparam int ML = 16;

  logic        reloj = 1'b0;
  logic        resetM = 1'b1;
  logic [6:0]  Qh = '0;
  logic [9:0]  Qv = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [5:0]  cfg_row = '0;
  logic [6:0]  cfg_col = '0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_blink = 1'b0;
  logic        chr_we = 1'b0;
  logic [1:0]  chr_sel = '0;
  logic [3:0]  chr_idx = '0;
  logic [7:0]  chr_code = '0;
  logic [19:0] DIR8x16;
  logic        dir_valid;

  int checks = 0;
  int errors = 0;

  always #5 reloj = ~reloj;

  text_label_addr_gen dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_len(cfg_len), .cfg_blink(cfg_blink),
    .chr_we(chr_we), .chr_sel(chr_sel), .chr_idx(chr_idx), .chr_code(chr_code),
    .DIR8x16(DIR8x16), .dir_valid(dir_valid)
  );

  // Reference model: label table, text table and the coordinate awaiting lookup.
  typedef struct { int addr; bit vld; } exp_t;
  exp_t exp_q[$];
  int m_row [NL];
  int m_col [NL];
  int m_len [NL];
  int m_text [NL][ML];
  bit p_vld = 0;
  int p_qh = 0;
  int p_qv = 0;

  function automatic exp_t lookup(input int qh, input int qv);
    exp_t e;
    int row;
    int line;
    e.addr = 0;
    e.vld  = 0;
    row  = qv / 16;
    line = qv % 16;
    for (int i = 0; i < NL; i++) begin
      if (m_len[i] != 0 && qh >= m_col[i] && qh < m_col[i] + 2 * m_len[i] &&
          (row == m_row[i] || row == m_row[i] + 1)) begin
        e.vld  = 1;
        e.addr = m_text[i][(qh - m_col[i]) / 2] * 32 + ((row == m_row[i]) ? 0 : 16) + line;
        return e;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [19:0] a_addr, input logic a_vld,
                       input logic [19:0] e_addr, input logic e_vld);
    checks++;
    if (a_addr !== e_addr || a_vld !== e_vld) begin
      errors++;
      $display("FAIL %s: got addr=%h valid=%b, expected addr=%h valid=%b",
               name, a_addr, a_vld, e_addr, e_vld);
    end
  endtask

  initial begin : model
    exp_t e;
    forever begin
      @(posedge reloj);
      e.addr = 0;
      e.vld  = 0;
      if (resetM) begin
        for (int i = 0; i < NL; i++) m_len[i] = 0;
        p_vld = 0;
      end else begin
        if (p_vld) e = lookup(p_qh, p_qv);
        if (cfg_we) begin
          m_row[cfg_sel] = int'(cfg_row);
          m_col[cfg_sel] = int'(cfg_col);
          m_len[cfg_sel] = int'(cfg_len);
        end
        if (chr_we) m_text[chr_sel][chr_idx] = int'(chr_code);
        p_vld = 1;
        p_qh  = int'(Qh);
        p_qv  = int'(Qv);
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge reloj);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got addr=%h valid=%b, expected a queued entry",
                 DIR8x16, dir_valid);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", DIR8x16, dir_valid, 20'(e.addr), e.vld);
      end
    end
  end

  task automatic set_label(input int sel, input int row, input int col, input int len);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_row = 6'(row); cfg_col = 7'(col); cfg_len = 5'(len);
    @(negedge reloj);
    cfg_we = 1'b0;
  endtask

  task automatic put_chr(input int sel, input int idx, input int code);
    chr_we = 1'b1; chr_sel = 2'(sel); chr_idx = 4'(idx); chr_code = 8'(code);
    @(negedge reloj);
    chr_we = 1'b0;
  endtask

  task automatic directed(input string name, input int qv, input int qh,
                          input int e_addr, input bit e_vld);
    Qv = 10'(qv);
    Qh = 7'(qh);
    @(negedge reloj);
    @(negedge reloj);
    check(name, DIR8x16, dir_valid, 20'(e_addr), e_vld);
    $display("lookup %s Qv=%0d Qh=%0d -> addr=%h valid=%b", name, qv, qh, DIR8x16, dir_valid);
  endtask

  initial begin : stimulus
    int s;
    @(negedge reloj);
    check("reset_state", DIR8x16, dir_valid, 20'h0, 1'b0);
    repeat (2) @(negedge reloj);
    resetM = 1'b0;

    // Fill every text cell while scanning; all labels are disabled.
    for (int sel = 0; sel < NL; sel++) begin
      for (int idx = 0; idx < ML; idx++) begin
        Qh = 7'($urandom);
        Qv = 10'($urandom);
        put_chr(sel, idx, int'($urandom_range(0, 255)));
      end
    end

    put_chr(0, 0, 'h48); put_chr(0, 1, 'h4F); put_chr(0, 2, 'h52); put_chr(0, 3, 'h41);
    set_label(0, 10, 12, 4);
    directed("basic_top",       160, 14, 'h9E0, 1);
    directed("basic_bottom",    191, 19, 'h83F, 1);
    directed("top_last_line",   175, 12, 'h90F, 1);
    directed("bottom_first",    176, 13, 'h910, 1);
    directed("left_edge_miss",  160, 11, 0, 0);
    directed("right_edge_miss", 160, 20, 0, 0);
    directed("below_miss",      192, 14, 0, 0);

    put_chr(1, 0, 'hAA); put_chr(1, 1, 'hBB);
    set_label(1, 10, 12, 2);
    directed("overlap_k0",  160, 12, 'h900, 1);
    directed("overlap_k1",  160, 15, 'h9E0, 1);
    directed("overlap_k2",  161, 16, 'hA41, 1);
    for (int qh = 8; qh < 25; qh++) begin
      Qv = 10'd165; Qh = 7'(qh);
      @(negedge reloj);
    end

    // Text write to the cell being looked up in the same cycle.
    Qv = 10'd160; Qh = 7'd14;
    @(negedge reloj);
    chr_we = 1'b1; chr_sel = 2'd0; chr_idx = 4'd1; chr_code = 8'h99;
    @(negedge reloj);
    chr_we = 1'b0;
    check("collision_old", DIR8x16, dir_valid, 20'h9E0, 1'b1);
    @(negedge reloj);
    check("collision_new", DIR8x16, dir_valid, 20'h1320, 1'b1);

    // Label at the last cell row, clipped at the right edge; its bottom half would wrap.
    set_label(2, 63, 120, 8);
    directed("row_wrap_miss", 3, 121, 0, 0);
    for (int qh = 116; qh < 128; qh++) begin
      Qv = 10'd1011; Qh = 7'(qh);
      @(negedge reloj);
      Qv = 10'd5;
      @(negedge reloj);
    end

    for (int n = 0; n < 3000; n++) begin
      cfg_we = 1'b0;
      chr_we = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        cfg_we  = 1'b1;
        cfg_sel = 2'($urandom);
        cfg_row = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom);
        cfg_col = 7'($urandom);
        cfg_len = 5'($urandom_range(0, 16));
      end
      if ($urandom_range(0, 3) == 0) begin
        chr_we   = 1'b1;
        chr_sel  = 2'($urandom);
        chr_idx  = 4'($urandom);
        chr_code = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 0) begin
        s  = int'($urandom_range(0, NL - 1));
        Qv = 10'(m_row[s] * 16 + int'($urandom_range(0, 31)));
        Qh = 7'(m_col[s] + int'($urandom_range(0, 40)) - 4);
      end else begin
        Qv = 10'($urandom);
        Qh = 7'($urandom);
      end
      @(negedge reloj);
    end
    cfg_we = 1'b0;
    chr_we = 1'b0;

    // Reset in the middle of a visible label.
    set_label(0, 10, 12, 4);
    Qv = 10'd160; Qh = 7'd14;
    repeat (2) @(negedge reloj);
    resetM = 1'b1;
    @(negedge reloj);
    check("reset_mid_frame", DIR8x16, dir_valid, 20'h0, 1'b0);
    resetM = 1'b0;
    for (int n = 0; n < 200; n++) begin
      Qv = 10'(152 + int'($urandom_range(0, 47)));
      Qh = 7'($urandom_range(8, 30));
      @(negedge reloj);
    end
    directed("disabled_after_reset", 160, 14, 0, 0);

    repeat (3) @(negedge reloj);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
